control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the instruction width.
REQ-002 Parameter D_ADDR_W, default 8, SHALL set the data-memory address width.
REQ-003 Parameter R_ADDR_W, default 4, SHALL set the register-file address width.
REQ-004 Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 IR  in  WIDTH  SHALL carry the current instruction from the instruction register.
REQ-007 PC_CLR  out  1  SHALL request clearing of the program counter.
REQ-008 PC_IC  out  1  SHALL request incrementing of the program counter.
REQ-009 IR_LD  out  1  SHALL request loading of the instruction register from instruction ROM.
REQ-010 D_WR  out  1  SHALL be the data-memory write enable.
REQ-011 RF_S  out  1  SHALL select the register-file write source: 1 = data memory, 0 = ALU.
REQ-012 RF_W_EN  out  1  SHALL be the register-file write enable.
REQ-013 D_ADDR  out  D_ADDR_W  SHALL be the data-memory address.
REQ-014 RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  R_ADDR_W each  SHALL be register-file read A, read B and write addresses.
REQ-015 ALU_S  out  4  SHALL be the ALU operation select.

Function
REQ-016 Opcode IR[15:12] SHALL decode as: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; all other codes SHALL be executed as NOOP.
REQ-017 Field mapping SHALL be: LOAD/STORE D_ADDR=IR[11:4], register=IR[3:0]; ADD/SUB RF_A_ADDR=IR[11:8], RF_B_ADDR=IR[7:4], RF_W_ADDR=IR[3:0].
REQ-018 The Moore FSM SHALL have states INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, NOOP, HALT.
REQ-019 Transitions SHALL be: INIT->FETCH; FETCH->DECODE; DECODE->state of the decoded opcode; LOAD_A->LOAD_B; LOAD_B, STORE, ADD, SUB and NOOP->FETCH; HALT->HALT.
REQ-020 Outputs SHALL be 0 in every state except as listed in REQ-021 to REQ-027.
REQ-021 INIT SHALL assert PC_CLR=1.
REQ-022 FETCH SHALL assert IR_LD=1 and PC_IC=1 in the same cycle.
REQ-023 LOAD_A SHALL drive D_ADDR=IR[11:4], RF_S=1 and RF_W_ADDR=IR[3:0].
REQ-024 LOAD_B SHALL drive the same outputs as LOAD_A, plus RF_W_EN=1.
REQ-025 STORE SHALL drive D_ADDR=IR[11:4], RF_A_ADDR=IR[3:0] and D_WR=1.
REQ-026 ADD and SUB SHALL drive the REQ-017 register addresses, RF_S=0 and RF_W_EN=1, with ALU_S=0001 (ADD) or ALU_S=0010 (SUB).
REQ-027 ALU_S SHALL be 0000 (pass A) in all other states.
REQ-028 Instruction latency SHALL be FETCH + DECODE + execute: 3 cycles, LOAD 4 cycles, HALT terminal.
REQ-029 Instruction ROM (instROM, 128x16, synchronous, 1-cycle read latency) SHALL be read with its address stable for at least one cycle before every FETCH.
REQ-030 The design SHALL rely on the REQ-029 ordering to make IR_LD capture the instruction at the updated PC.
REQ-031 Program-counter wrap from 127 to 0 SHALL be handled outside this block; the FSM SHALL be unaffected.

Reset
REQ-032 Reset=1 at a rising edge SHALL force state INIT, overriding any state including mid-LOAD and HALT.
REQ-033 While in INIT, outputs SHALL be PC_CLR=1 and all others 0.
REQ-034 Reset SHALL be held for at least 2 cycles so the ROM presents address 0 before the first FETCH.

Structure
REQ-035 A shared package SHALL hold the opcode enum, the ALU_S constants (PASS=0, ADD=1, SUB=2) and the state enum.
REQ-036 The block SHALL be one module with a registered state and a combinational next-state/output decoder, and no sub-module.
REQ-037 The PC, IR and instROM SHALL live in the parent controller.

Verification
REQ-038 Reset held 2 cycles, then released -> PC_CLR=1 during reset; next cycle IR_LD=1 and PC_IC=1.
REQ-039 IR=16'h2053 (LOAD) -> LOAD_A: D_ADDR=8'h05, RF_S=1, RF_W_ADDR=3, RF_W_EN=0; LOAD_B: RF_W_EN=1; then FETCH.
REQ-040 IR=16'h1A21 (STORE) -> D_WR=1 for exactly 1 cycle with D_ADDR=8'hA2 and RF_A_ADDR=1.
REQ-041 IR=16'h3125 (ADD) and IR=16'h4125 (SUB) -> RF_A_ADDR=1, RF_B_ADDR=2, RF_W_ADDR=5, RF_W_EN=1, ALU_S=1 for ADD and 2 for SUB.
REQ-042 IR=16'h5000 (HALT) -> all outputs 0 indefinitely with no further IR_LD; Reset pulse -> INIT.
REQ-043 IR=16'hF000 (undefined opcode) -> NOOP behaviour and return to FETCH after 3 cycles.

Source files
------------

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, ALU selects, FSM states and opcode decode helper
package control_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_e;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_ADD    = 4'd6,
        ST_SUB    = 4'd7,
        ST_NOOP   = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    // Execute state for an opcode; codes with no meaning run as NOOP.
    function automatic state_e decode_op(input logic [3:0] op);
        case (op)
            OP_STORE: decode_op = ST_STORE;
            OP_LOAD:  decode_op = ST_LOAD_A;
            OP_ADD:   decode_op = ST_ADD;
            OP_SUB:   decode_op = ST_SUB;
            OP_HALT:  decode_op = ST_HALT;
            default:  decode_op = ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore FSM sequencing fetch/decode/execute for a 16-bit micro-controller
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [WIDTH-1:0]    i_ir,
    output logic                o_pc_clr,
    output logic                o_pc_ic,
    output logic                o_ir_ld,
    output logic                o_d_wr,
    output logic                o_rf_s,
    output logic                o_rf_w_en,
    output logic [D_ADDR_W-1:0] o_d_addr,
    output logic [R_ADDR_W-1:0] o_rf_a_addr,
    output logic [R_ADDR_W-1:0] o_rf_b_addr,
    output logic [R_ADDR_W-1:0] o_rf_w_addr,
    output logic [3:0]          o_alu_s
);

    localparam logic [3:0] S_INIT   = ST_INIT;
    localparam logic [3:0] S_FETCH  = ST_FETCH;
    localparam logic [3:0] S_DECODE = ST_DECODE;
    localparam logic [3:0] S_LOAD_A = ST_LOAD_A;
    localparam logic [3:0] S_LOAD_B = ST_LOAD_B;
    localparam logic [3:0] S_STORE  = ST_STORE;
    localparam logic [3:0] S_ADD    = ST_ADD;
    localparam logic [3:0] S_SUB    = ST_SUB;
    localparam logic [3:0] S_NOOP   = ST_NOOP;
    localparam logic [3:0] S_HALT   = ST_HALT;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [3:0]          w_opcode;
    logic [D_ADDR_W-1:0] w_mem_addr;
    logic [R_ADDR_W-1:0] w_reg_a;
    logic [R_ADDR_W-1:0] w_reg_b;
    logic [R_ADDR_W-1:0] w_reg_w;

    // Instruction fields; LOAD/STORE share the low nibble as their register.
    assign w_opcode   = i_ir[WIDTH-1 -: 4];
    assign w_mem_addr = i_ir[4 +: D_ADDR_W];
    assign w_reg_a    = i_ir[8 +: R_ADDR_W];
    assign w_reg_b    = i_ir[4 +: R_ADDR_W];
    assign w_reg_w    = i_ir[0 +: R_ADDR_W];

    // State register; reset wins over every state, HALT included.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decoder; HALT only leaves through reset.
    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = decode_op(w_opcode);
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_NOOP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Moore outputs; LOAD is split so the memory read settles before the write-back.
    always_comb begin
        o_pc_clr    = 1'b0;
        o_pc_ic     = 1'b0;
        o_ir_ld     = 1'b0;
        o_d_wr      = 1'b0;
        o_rf_s      = 1'b0;
        o_rf_w_en   = 1'b0;
        o_d_addr    = '0;
        o_rf_a_addr = '0;
        o_rf_b_addr = '0;
        o_rf_w_addr = '0;
        o_alu_s     = ALU_PASS;
        case (r_state)
            S_INIT: begin
                o_pc_clr = 1'b1;
            end
            S_FETCH: begin
                o_ir_ld = 1'b1;
                o_pc_ic = 1'b1;
            end
            S_LOAD_A: begin
                o_d_addr    = w_mem_addr;
                o_rf_s      = 1'b1;
                o_rf_w_addr = w_reg_w;
            end
            S_LOAD_B: begin
                o_d_addr    = w_mem_addr;
                o_rf_s      = 1'b1;
                o_rf_w_addr = w_reg_w;
                o_rf_w_en   = 1'b1;
            end
            S_STORE: begin
                o_d_addr    = w_mem_addr;
                o_rf_a_addr = w_reg_w;
                o_d_wr      = 1'b1;
            end
            S_ADD, S_SUB: begin
                o_rf_a_addr = w_reg_a;
                o_rf_b_addr = w_reg_b;
                o_rf_w_addr = w_reg_w;
                o_rf_w_en   = 1'b1;
                o_alu_s     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for the control_unit FSM
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        pc_clr, pc_ic, ir_ld, d_wr, rf_s, rf_w_en;
    logic [7:0]  d_addr;
    logic [3:0]  rf_a, rf_b, rf_w, alu_s;
    logic [29:0] obs;
    logic [29:0] e;
    logic [29:0] sb[$];
    int          n_vec;
    int          n_bad;

    control_unit #(.WIDTH(16), .D_ADDR_W(8), .R_ADDR_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_ir(ir),
        .o_pc_clr(pc_clr), .o_pc_ic(pc_ic), .o_ir_ld(ir_ld), .o_d_wr(d_wr),
        .o_rf_s(rf_s), .o_rf_w_en(rf_w_en), .o_d_addr(d_addr),
        .o_rf_a_addr(rf_a), .o_rf_b_addr(rf_b), .o_rf_w_addr(rf_w), .o_alu_s(alu_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {pc_clr, pc_ic, ir_ld, d_wr, rf_s, rf_w_en, d_addr, rf_a, rf_b, rf_w, alu_s};

    function automatic logic [29:0] mk(input logic clr, input logic ic, input logic ld,
                                       input logic wr, input logic s, input logic wen,
                                       input logic [7:0] da, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] w,
                                       input logic [3:0] alu);
        mk = {clr, ic, ld, wr, s, wen, da, a, b, w, alu};
    endfunction

    localparam logic [29:0] V_INIT  = {1'b1, 29'd0};
    localparam logic [29:0] V_FETCH = {1'b0, 1'b1, 1'b1, 27'd0};
    localparam logic [29:0] V_ZERO  = 30'd0;

    // Expected execute-phase vectors for an instruction, from the field map.
    task automatic push_exec(input logic [15:0] inst);
        case (inst[15:12])
            4'h1: sb.push_back(mk(0,0,0,1,0,0, inst[11:4], inst[3:0], 4'h0, 4'h0, 4'h0));
            4'h2: begin
                sb.push_back(mk(0,0,0,0,1,0, inst[11:4], 4'h0, 4'h0, inst[3:0], 4'h0));
                sb.push_back(mk(0,0,0,0,1,1, inst[11:4], 4'h0, 4'h0, inst[3:0], 4'h0));
            end
            4'h3: sb.push_back(mk(0,0,0,0,0,1, 8'h00, inst[11:8], inst[7:4], inst[3:0], 4'h1));
            4'h4: sb.push_back(mk(0,0,0,0,0,1, 8'h00, inst[11:8], inst[7:4], inst[3:0], 4'h2));
            default: sb.push_back(V_ZERO);
        endcase
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ir  = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(V_INIT);
        sb.push_back(V_INIT);
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h expected %h", k, obs, e);
            end
            if (k == 1) rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        ir = 16'h2053;
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        sb.push_back(mk(0,0,0,0,1,0, 8'h05, 4'h0, 4'h0, 4'h3, 4'h0));
        sb.push_back(mk(0,0,0,0,1,1, 8'h05, 4'h0, 4'h0, 4'h3, 4'h0));
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL load[%0d]: got %h expected %h", k, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store;
        ir = 16'h1A21;
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        sb.push_back(mk(0,0,0,1,0,0, 8'hA2, 4'h1, 4'h0, 4'h0, 4'h0));
        sb.push_back(V_FETCH);
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL store[%0d]: got %h expected %h", k, obs, e);
            end
            if (k < 3) @(negedge clk);
        end
    endtask

    task automatic test_add_sub;
        ir = 16'h3125;
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        sb.push_back(mk(0,0,0,0,0,1, 8'h00, 4'h1, 4'h2, 4'h5, 4'h1));
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        sb.push_back(mk(0,0,0,0,0,1, 8'h00, 4'h1, 4'h2, 4'h5, 4'h2));
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL add_sub[%0d]: got %h expected %h", k, obs, e);
            end
            if (k == 2) ir = 16'h4125;
            @(negedge clk);
        end
    endtask

    task automatic test_noop_undefined;
        logic [15:0] codes [4];
        codes[0] = 16'h0000;
        codes[1] = 16'hF000;
        codes[2] = 16'h6123;
        codes[3] = 16'hE0FF;
        for (int i = 0; i < 4; i++) begin
            ir = codes[i];
            sb.push_back(V_FETCH);
            sb.push_back(V_ZERO);
            sb.push_back(V_ZERO);
            for (int k = 0; sb.size() > 0; k++) begin
                #1;
                e = sb.pop_front();
                n_vec++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL noop_%h[%0d]: got %h expected %h", codes[i], k, obs, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] inst;
        logic [3:0]  ops [5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'h4;
        for (int i = 0; i < 12; i++) begin
            inst = {ops[$urandom_range(0, 4)], 12'($urandom)};
            ir   = inst;
            sb.push_back(V_FETCH);
            sb.push_back(V_ZERO);
            push_exec(inst);
            for (int k = 0; sb.size() > 0; k++) begin
                #1;
                e = sb.pop_front();
                n_vec++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL b2b_%h[%0d]: got %h expected %h", inst, k, obs, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        ir = 16'h27C9;
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        sb.push_back(mk(0,0,0,0,1,0, 8'h7C, 4'h0, 4'h0, 4'h9, 4'h0));
        sb.push_back(V_INIT);
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_mid_load[%0d]: got %h expected %h", k, obs, e);
            end
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_halt;
        ir = 16'h5000;
        sb.push_back(V_FETCH);
        sb.push_back(V_ZERO);
        for (int i = 0; i < 10; i++) sb.push_back(V_ZERO);
        sb.push_back(V_INIT);
        sb.push_back(V_FETCH);
        for (int k = 0; sb.size() > 0; k++) begin
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL halt[%0d]: got %h expected %h", k, obs, e);
            end
            if (k == 11) rst = 1'b1;
            if (k == 12) rst = 1'b0;
            if (k < 13) @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        ir    = 16'h0000;
        test_reset;
        test_load;
        test_store;
        test_add_sub;
        test_noop_undefined;
        test_back_to_back;
        test_reset_mid_load;
        test_halt;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
